mux_n_pipe: RTL

Parametrised, registered N-way data selector with a valid/ready handshake and a one-entry skid buffer, for pipeline stages that need more than four sources, such as forwarding and writeback select. Each accepted beat picks one WIDTH-bit lane from a flattened input bus and presents it one cycle later. A stalled consumer never loses data. A flush empties the stage in one cycle.

---
 rtl/mux_n_pipe.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mux_n_pipe.sv
// Registered N-way lane selector with valid/ready handshake and one-entry skid buffer.
// Optional sticky out-of-range select flag enabled by defining MUX_N_PIPE_ERR_EN.

module mux_n_pipe #(
    parameter int WIDTH = 32,
    parameter int NUM   = 4,
    parameter int SEL_W = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]     select_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic                 flush_i,
    output logic [WIDTH-1:0]     data_o,
    output logic [SEL_W-1:0]     sel_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 err_o
);

    // state | meaning
    // EMPTY | no beat held, valid_o=0, ready_o=1
    // FULL  | output register holds a beat, ready_o=1
    // SKID  | output and skid registers both hold a beat, ready_o=0
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_SKID
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] lane_data;
    logic [WIDTH-1:0] skid_data;
    logic [SEL_W-1:0] skid_sel;
    logic             accept;

    assign accept = valid_i && ready_o;

    // Selects with no matching lane fall through to zero data.
    always_comb begin
        lane_data = '0;
        for (int k = 0; k < NUM; k++) begin
            if (select_i == k[SEL_W-1:0]) begin
                lane_data = data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_EMPTY;
            valid_o   <= 1'b0;
            ready_o   <= 1'b1;
            data_o    <= '0;
            sel_o     <= '0;
            skid_data <= '0;
            skid_sel  <= '0;
        end else if (flush_i) begin
            state   <= ST_EMPTY;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        data_o  <= lane_data;
                        sel_o   <= select_i;
                        valid_o <= 1'b1;
                        state   <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (ready_i && accept) begin
                        data_o <= lane_data;
                        sel_o  <= select_i;
                    end else if (ready_i) begin
                        valid_o <= 1'b0;
                        state   <= ST_EMPTY;
                    end else if (accept) begin
                        skid_data <= lane_data;
                        skid_sel  <= select_i;
                        ready_o   <= 1'b0;
                        state     <= ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (ready_i) begin
                        data_o  <= skid_data;
                        sel_o   <= skid_sel;
                        ready_o <= 1'b1;
                        state   <= ST_FULL;
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

`ifdef MUX_N_PIPE_ERR_EN
    logic sel_oob;

    always_comb begin
        sel_oob = 1'b1;
        for (int k = 0; k < NUM; k++) begin
            if (select_i == k[SEL_W-1:0]) begin
                sel_oob = 1'b0;
            end
        end
    end

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (accept && sel_oob) begin
            err_o <= 1'b1;
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule
